// File: rtl/demo_scene_sequencer_if.sv
// Scene sequencer bus: frame/music/skip/cue-write inputs and the registered scene outputs.
interface demo_scene_sequencer_if #(
  parameter int unsigned SCENE_W = 2,
  parameter int unsigned POS_W   = 11,
  parameter int unsigned PHASE_W = 6
);
  logic               frame_tick;
  logic [POS_W-1:0]   song_position;
  logic               skip;
  logic               cue_wr_en;
  logic [SCENE_W-1:0] cue_wr_idx;
  logic [POS_W-1:0]   cue_wr_pos;
  logic [SCENE_W-1:0] cur_scene;
  logic [SCENE_W-1:0] next_scene;
  logic               trans_active;
  logic [PHASE_W-1:0] trans_phase;
  logic               scene_start;

  modport master (
    output frame_tick, song_position, skip, cue_wr_en, cue_wr_idx, cue_wr_pos,
    input  cur_scene, next_scene, trans_active, trans_phase, scene_start
  );

  modport slave (
    input  frame_tick, song_position, skip, cue_wr_en, cue_wr_idx, cue_wr_pos,
    output cur_scene, next_scene, trans_active, trans_phase, scene_start
  );
endinterface

// File: rtl/demo_scene_sequencer.sv
// Frame-synchronous scene scheduler: picks the displayed scene from a cue table, song wrap
// and user skip, and steps cross-fades one phase per frame.
module demo_scene_sequencer #(
  parameter int unsigned NUM_SCENES   = 4,
  parameter int unsigned SCENE_W      = 2,
  parameter int unsigned POS_W        = 11,
  parameter int unsigned TRANS_FRAMES = 64,
  parameter int unsigned PHASE_W      = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  demo_scene_sequencer_if.slave   bus
);

  typedef enum logic {HOLD, TRANS} state_e;

  state_e             state_q, state_d;
  logic [SCENE_W-1:0] cur_q, cur_d;
  logic [SCENE_W-1:0] next_q, next_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               start_q, start_d;
  logic               pend_q, pend_d;
  logic               skip_q;
  logic [POS_W-1:0]   last_pos_q;
  logic [POS_W-1:0]   cue_q [NUM_SCENES];

  logic               skip_rise, wrap, pend_eff, go;
  logic [SCENE_W-1:0] tgt, cur_inc;

  assign skip_rise = bus.skip & ~skip_q;
  assign wrap      = bus.frame_tick & (bus.song_position < last_pos_q);
  assign cur_inc   = (cur_q == SCENE_W'(NUM_SCENES - 1)) ? '0 : cur_q + SCENE_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= HOLD;
      cur_q      <= '0;
      next_q     <= '0;
      phase_q    <= '0;
      start_q    <= 1'b0;
      pend_q     <= 1'b0;
      skip_q     <= 1'b0;
      last_pos_q <= '0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      next_q     <= next_d;
      phase_q    <= phase_d;
      start_q    <= start_d;
      pend_q     <= pend_d;
      skip_q     <= bus.skip;
      if (bus.frame_tick) last_pos_q <= bus.song_position;
    end
  end

  // Cue reads in the next-state logic see the pre-write value, so a write on a tick edge applies from the next tick.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_SCENES; i++) cue_q[i] <= POS_W'(i * 256);
    end else if (bus.cue_wr_en) begin
      cue_q[bus.cue_wr_idx] <= bus.cue_wr_pos;
    end
  end

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    next_d   = next_q;
    phase_d  = phase_q;
    start_d  = 1'b0;
    pend_d   = pend_q;
    pend_eff = pend_q | skip_rise;
    go       = 1'b0;
    tgt      = cur_q;
    unique case (state_q)
      HOLD: begin
        pend_d = pend_eff;
        if (bus.frame_tick) begin
          if (wrap && (cur_q != '0)) begin
            go  = 1'b1;
            tgt = '0;
          end else if (pend_eff) begin
            go  = 1'b1;
            tgt = cur_inc;
          end else if ((cur_q < SCENE_W'(NUM_SCENES - 1)) &&
                       (bus.song_position >= cue_q[cur_q + SCENE_W'(1)])) begin
            go  = 1'b1;
            tgt = cur_q + SCENE_W'(1);
          end
        end
        if (go) begin
          state_d = TRANS;
          next_d  = tgt;
          phase_d = '0;
          pend_d  = 1'b0;
        end
      end
      TRANS: begin
        pend_d = 1'b0;
        if (bus.frame_tick) begin
          if (phase_q == PHASE_W'(TRANS_FRAMES - 1)) begin
            state_d = HOLD;
            cur_d   = next_q;
            phase_d = '0;
            start_d = 1'b1;
          end else begin
            phase_d = phase_q + PHASE_W'(1);
          end
        end
      end
      default: state_d = HOLD;
    endcase
  end

  always_comb begin
    bus.cur_scene    = cur_q;
    bus.next_scene   = next_q;
    bus.trans_active = (state_q == TRANS);
    bus.trans_phase  = phase_q;
    bus.scene_start  = start_q;
  end

endmodule

// File: tb/tb_demo_scene_sequencer.sv
// Directed plus randomized bench for demo_scene_sequencer against a frame-level reference model.
module tb_demo_scene_sequencer;
  localparam int NS  = 4;
  localparam int SW  = 2;
  localparam int PW  = 11;
  localparam int TF  = 64;
  localparam int PHW = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  demo_scene_sequencer_if #(.SCENE_W(SW), .POS_W(PW), .PHASE_W(PHW)) bus();

  demo_scene_sequencer #(
    .NUM_SCENES(NS), .SCENE_W(SW), .POS_W(PW), .TRANS_FRAMES(TF), .PHASE_W(PHW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: scene shown, pending target, frames into the current fade
  int m_cur, m_next, m_prog, m_last;
  bit m_trans, m_start, m_pend, m_skprev;
  int m_cue [NS];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_step();
    bit rise, wrap, tick;
    int tgt;
    if (!rst_n) begin
      m_cur = 0; m_next = 0; m_prog = 0; m_last = 0;
      m_trans = 0; m_start = 0; m_pend = 0; m_skprev = 0;
      for (int i = 0; i < NS; i++) m_cue[i] = i * 256;
      return;
    end
    tick    = bus.frame_tick;
    rise    = bus.skip && !m_skprev;
    wrap    = tick && (int'(bus.song_position) < m_last);
    m_start = 0;
    if (!m_trans) begin
      m_pend = m_pend || rise;
      if (tick) begin
        tgt = -1;
        if (wrap && m_cur != 0) tgt = 0;
        else if (m_pend) tgt = (m_cur + 1) % NS;
        else if (m_cur < NS - 1 && int'(bus.song_position) >= m_cue[m_cur + 1]) tgt = m_cur + 1;
        if (tgt >= 0) begin
          m_trans = 1; m_next = tgt; m_prog = 0; m_pend = 0;
        end
      end
    end else if (tick) begin
      if (m_prog == TF - 1) begin
        m_cur = m_next; m_trans = 0; m_prog = 0; m_start = 1;
      end else begin
        m_prog++;
      end
    end
    if (tick) m_last = int'(bus.song_position);
    m_skprev = bus.skip;
    if (bus.cue_wr_en) m_cue[bus.cue_wr_idx] = int'(bus.cue_wr_pos);
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    chk("cur_scene",    32'(bus.cur_scene),    m_cur);
    chk("next_scene",   32'(bus.next_scene),   m_trans ? m_next : m_cur);
    chk("trans_active", 32'(bus.trans_active), 32'(m_trans));
    chk("trans_phase",  32'(bus.trans_phase),  m_prog);
    chk("scene_start",  32'(bus.scene_start),  32'(m_start));
  endtask

  task automatic frame();
    bus.frame_tick = 1'b1;
    cyc();
    bus.frame_tick = 1'b0;
    cyc();
  endtask

  task automatic run_to_idle(input int max_frames);
    for (int n = 0; n < max_frames && m_trans; n++) frame();
  endtask

  task automatic write_cue(input int idx, input int pos);
    bus.cue_wr_en  = 1'b1;
    bus.cue_wr_idx = SW'(idx);
    bus.cue_wr_pos = PW'(pos);
    cyc();
    bus.cue_wr_en  = 1'b0;
  endtask

  task automatic skip_pulse();
    bus.skip = 1'b1;
    cyc();
    bus.skip = 1'b0;
    cyc();
  endtask

  int pos;

  initial begin
    bus.frame_tick = 1'b0; bus.song_position = '0; bus.skip = 1'b0;
    bus.cue_wr_en = 1'b0; bus.cue_wr_idx = '0; bus.cue_wr_pos = '0;

    // Reset state
    rst_n = 1'b0;
    cyc(); cyc();
    chk("rst_cur",    32'(bus.cur_scene),    0);
    chk("rst_next",   32'(bus.next_scene),   0);
    chk("rst_active", 32'(bus.trans_active), 0);
    chk("rst_phase",  32'(bus.trans_phase),  0);
    chk("rst_start",  32'(bus.scene_start),  0);
    rst_n = 1'b1;
    cyc();

    // Song ramp crosses the default cue for scene 1 at 260
    for (pos = 0; pos <= 300; pos += 10) begin
      bus.song_position = PW'(pos);
      frame();
      if (pos == 250) chk("ramp_before_cue", 32'(bus.trans_active), 0);
      if (pos == 260) chk("ramp_enter_next", 32'(bus.next_scene), 1);
    end
    run_to_idle(80);
    chk("ramp_cur", 32'(bus.cur_scene), 1);

    // Skip-driven walk to scene 3 with cues parked out of reach, then skip to 0
    for (int i = 1; i < NS; i++) write_cue(i, 2047);
    bus.song_position = PW'(900);
    skip_pulse(); frame(); run_to_idle(80);
    skip_pulse(); frame(); run_to_idle(80);
    chk("skip_at3", 32'(bus.cur_scene), 3);
    skip_pulse(); frame();
    chk("skip_wrap_next", 32'(bus.next_scene), 0);
    for (int i = 0; i < 5; i++) frame();
    skip_pulse();
    run_to_idle(80);
    for (int i = 0; i < 5; i++) frame();
    chk("skip_stays0", 32'(bus.cur_scene), 0);

    // Song wrap beats a simultaneous skip
    for (int i = 1; i < NS; i++) write_cue(i, i * 256);
    bus.song_position = PW'(600);
    for (int n = 0; n < 200 && !(m_cur == 2 && !m_trans); n++) frame();
    chk("wrap_at2", 32'(bus.cur_scene), 2);
    bus.song_position = PW'(5);
    bus.skip = 1'b1;
    frame();
    bus.skip = 1'b0;
    chk("wrap_next", 32'(bus.next_scene), 0);
    run_to_idle(80);
    chk("wrap_cur", 32'(bus.cur_scene), 0);

    // Cue rewrite takes effect at the next tick
    bus.song_position = PW'(40);
    frame();
    write_cue(1, 50);
    bus.song_position = PW'(60);
    frame();
    chk("cue_active", 32'(bus.trans_active), 1);
    chk("cue_next",   32'(bus.next_scene),   1);

    // Reset mid-transition
    for (int n = 0; n < 40 && m_prog < 30; n++) frame();
    chk("midrst_phase", 32'(bus.trans_phase), 30);
    rst_n = 1'b0;
    cyc();
    chk("midrst_active", 32'(bus.trans_active), 0);
    chk("midrst_phase0", 32'(bus.trans_phase),  0);
    chk("midrst_start",  32'(bus.scene_start),  0);
    rst_n = 1'b1;
    cyc();

    // No frame ticks: nothing moves even with the cue satisfied
    bus.song_position = PW'(2000);
    for (int i = 0; i < 1000; i++) cyc();
    chk("notick_active", 32'(bus.trans_active), 0);

    // Randomized traffic
    pos = 2000;
    for (int c = 0; c < 6000; c++) begin
      bus.frame_tick = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 19) == 0) bus.skip = ~bus.skip;
      bus.cue_wr_en = ($urandom_range(0, 29) == 0);
      bus.cue_wr_idx = SW'($urandom_range(0, NS - 1));
      bus.cue_wr_pos = PW'($urandom_range(0, 1023));
      if (bus.frame_tick) begin
        if ($urandom_range(0, 59) == 0) pos = $urandom_range(0, 63);
        else pos = (pos + $urandom_range(0, 12) > 2047) ? 2047 : pos + $urandom_range(0, 12);
        bus.song_position = PW'(pos);
      end
      rst_n = ($urandom_range(0, 2999) != 0);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
